// File: rtl/osc_ctrl.sv
// Runtime-programmable antenna square-wave oscillator. New half-periods take
// effect only at toggle boundaries, and start/stop sequencing always parks the output low.
module osc_ctrl #(
    parameter int unsigned          WIDTH        = 32,
    parameter logic [WIDTH-1:0]     DEFAULT_HALF = WIDTH'(10_000)
) (
    input  logic             clk_100,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_half,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             ant_out,
    output logic             edge_stb,
    output logic             applied_stb,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] active_half_q;
    logic [WIDTH-1:0] pending_half_q;
    logic             pending_v_q;
    logic             ant_q;
    logic             edge_q;
    logic             applied_q;

    logic             terminal;
    logic             capture;
    logic [WIDTH-1:0] cfg_half_d;
    logic             ant_d;

    // A zero half-period would never terminate, so it is promoted to one.
    assign cfg_half_d = (cfg_half == '0) ? ONE : cfg_half;
    assign capture    = cfg_valid && !pending_v_q;
    assign terminal   = (counter_q == (active_half_q - ONE));
    assign ant_d      = terminal ? ~ant_q : ant_q;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q        <= IDLE;
            counter_q      <= '0;
            active_half_q  <= DEFAULT_HALF;
            pending_half_q <= '0;
            pending_v_q    <= 1'b0;
            ant_q          <= 1'b0;
            edge_q         <= 1'b0;
            applied_q      <= 1'b0;
        end else begin
            edge_q    <= 1'b0;
            applied_q <= 1'b0;

            // Capture and apply never coincide: capture needs the buffer empty.
            if (capture) begin
                pending_half_q <= cfg_half_d;
                pending_v_q    <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    ant_q     <= 1'b0;
                    counter_q <= '0;
                    if (pending_v_q) begin
                        active_half_q <= pending_half_q;
                        pending_v_q   <= 1'b0;
                        applied_q     <= 1'b1;
                    end
                    if (enable) begin
                        state_q <= RUN;
                    end
                end

                RUN, STOP: begin
                    if (terminal) begin
                        ant_q     <= ~ant_q;
                        edge_q    <= 1'b1;
                        counter_q <= '0;
                        if (pending_v_q) begin
                            active_half_q <= pending_half_q;
                            pending_v_q   <= 1'b0;
                            applied_q     <= 1'b1;
                        end
                    end else begin
                        counter_q <= counter_q + ONE;
                    end

                    // On disable, park at once if the output is (or is about to be) low.
                    if (state_q == RUN) begin
                        if (!enable) begin
                            if (!ant_d) begin
                                state_q   <= IDLE;
                                counter_q <= '0;
                            end else begin
                                state_q <= STOP;
                            end
                        end
                    end else if (enable) begin
                        state_q <= RUN;
                    end else if (terminal) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready   = ~pending_v_q;
    assign ant_out     = ant_q;
    assign edge_stb    = edge_q;
    assign applied_stb = applied_q;
    assign running     = (state_q != IDLE);

endmodule

// File: tb/tb_osc_ctrl.sv
// Directed bench for osc_ctrl: half-period timing, config handshake, stop parking
// and reset abort, each checked against hand-computed cycle counts.
module tb_osc_ctrl;

    logic        clk_100;
    logic        reset;
    logic        enable;
    logic [31:0] cfg_half;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ant_out;
    logic        edge_stb;
    logic        applied_stb;
    logic        running;

    int nChecks;
    int nFails;

    osc_ctrl dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .enable     (enable),
        .cfg_half   (cfg_half),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .ant_out    (ant_out),
        .edge_stb   (edge_stb),
        .applied_stb(applied_stb),
        .running    (running)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    // Counts rising clock edges until ant_out changes, sampling on falling edges.
    task automatic wait_toggle(input int limit, output int cycles, output int edges,
                               output int applies);
        logic start;
        start   = ant_out;
        cycles  = 0;
        edges   = 0;
        applies = 0;
        while (ant_out === start && cycles < limit) begin
            @(negedge clk_100);
            cycles++;
            if (edge_stb === 1'b1) edges++;
            if (applied_stb === 1'b1) applies++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        repeat (3) @(negedge clk_100);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nChecks++;
        if ({ant_out, edge_stb, applied_stb, running, cfg_ready} !== 5'b00001) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %b expected 00001",
                     {ant_out, edge_stb, applied_stb, running, cfg_ready});
        end
    endtask

    task automatic test_default_run();
        int c, e, a;
        enable = 1'b1;
        wait_toggle(20000, c, e, a);
        nChecks++;
        if (c !== 10001) begin
            nFails++;
            $display("[TB] FAIL first_rise: got %0d cycles expected 10001", c);
        end
        nChecks++;
        if (e !== 1 || running !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL first_rise_stb: got edges=%0d running=%b expected 1 1", e, running);
        end
        wait_toggle(20000, c, e, a);
        nChecks++;
        if (c !== 10000 || e !== 1 || ant_out !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL default_half: got %0d/%0d/%b expected 10000/1/0", c, e, ant_out);
        end
    endtask

    task automatic test_reconfig();
        int c, e, a;
        repeat (5) @(negedge clk_100);
        cfg_half  = 32'd4;
        cfg_valid = 1'b1;
        @(negedge clk_100);
        cfg_valid = 1'b0;
        nChecks++;
        if (cfg_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reconfig_ready_low: got %b expected 0", cfg_ready);
        end
        wait_toggle(20000, c, e, a);
        nChecks++;
        if (c + 6 !== 10000 || a !== 1) begin
            nFails++;
            $display("[TB] FAIL reconfig_current_half: got %0d applies=%0d expected 10000 1",
                     c + 6, a);
        end
        nChecks++;
        if (cfg_ready !== 1'b1 || applied_stb !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reconfig_apply: got ready=%b applied=%b expected 1 1",
                     cfg_ready, applied_stb);
        end
        for (int i = 0; i < 2; i++) begin
            wait_toggle(100, c, e, a);
            nChecks++;
            if (c !== 4 || e !== 1 || a !== 0) begin
                nFails++;
                $display("[TB] FAIL reconfig_new_half: got %0d/%0d/%0d expected 4/1/0", c, e, a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, e, a;
        do_reset();
        enable    = 1'b1;
        cfg_half  = 32'd8;
        cfg_valid = 1'b1;
        @(negedge clk_100);
        nChecks++;
        if (cfg_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_first_capture: got ready=%b expected 0", cfg_ready);
        end
        cfg_half = 32'd6;
        wait_toggle(20000, c, e, a);
        nChecks++;
        if (c + 1 !== 10001 || a !== 1 || cfg_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_first_half: got %0d/%0d/%b expected 10001/1/1",
                     c + 1, a, cfg_ready);
        end
        @(negedge clk_100);
        cfg_valid = 1'b0;
        nChecks++;
        if (cfg_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_second_capture: got ready=%b expected 0", cfg_ready);
        end
        wait_toggle(100, c, e, a);
        nChecks++;
        if (c + 1 !== 8 || a !== 1) begin
            nFails++;
            $display("[TB] FAIL b2b_half8: got %0d applies=%0d expected 8 1", c + 1, a);
        end
        wait_toggle(100, c, e, a);
        nChecks++;
        if (c !== 6 || a !== 0) begin
            nFails++;
            $display("[TB] FAIL b2b_half6: got %0d applies=%0d expected 6 0", c, a);
        end
    endtask

    task automatic test_stop();
        int c, e, a;
        do_reset();
        cfg_half  = 32'd4;
        cfg_valid = 1'b1;
        @(negedge clk_100);
        cfg_valid = 1'b0;
        @(negedge clk_100);
        nChecks++;
        if (applied_stb !== 1'b1 || cfg_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL idle_apply: got applied=%b ready=%b expected 1 1",
                     applied_stb, cfg_ready);
        end
        enable = 1'b1;
        wait_toggle(100, c, e, a);
        enable = 1'b0;
        nChecks++;
        if (c !== 5 || ant_out !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL stop_rise: got %0d ant=%b expected 5 1", c, ant_out);
        end
        @(negedge clk_100);
        nChecks++;
        if (running !== 1'b1 || ant_out !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL stop_hold_high: got running=%b ant=%b expected 1 1",
                     running, ant_out);
        end
        wait_toggle(100, c, e, a);
        nChecks++;
        if (c + 1 !== 4 || running !== 1'b0 || ant_out !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL stop_park: got %0d running=%b ant=%b expected 4 0 0",
                     c + 1, running, ant_out);
        end
        wait_toggle(10, c, e, a);
        nChecks++;
        if (c !== 10 || e !== 0 || running !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL stop_stays_low: got %0d edges=%0d running=%b expected 10 0 0",
                     c, e, running);
        end
        enable = 1'b1;
        wait_toggle(100, c, e, a);
        enable = 1'b0;
        @(negedge clk_100);
        nChecks++;
        if (running !== 1'b1 || ant_out !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL restop_state: got running=%b ant=%b expected 1 1",
                     running, ant_out);
        end
        enable = 1'b1;
        wait_toggle(100, c, e, a);
        nChecks++;
        if (c + 1 !== 4 || running !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL resume_phase: got %0d running=%b expected 4 1", c + 1, running);
        end
        wait_toggle(100, c, e, a);
        nChecks++;
        if (c !== 4 || ant_out !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL resume_next: got %0d ant=%b expected 4 1", c, ant_out);
        end
    endtask

    task automatic test_min_half();
        int c, e, a;
        logic [31:0] vals [2];
        vals[0] = 32'd0;
        vals[1] = 32'd1;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cfg_half  = vals[v];
            cfg_valid = 1'b1;
            @(negedge clk_100);
            cfg_valid = 1'b0;
            @(negedge clk_100);
            enable = 1'b1;
            wait_toggle(100, c, e, a);
            nChecks++;
            if (c !== 2) begin
                nFails++;
                $display("[TB] FAIL min_first_rise cfg=%0d: got %0d expected 2", vals[v], c);
            end
            for (int i = 0; i < 3; i++) begin
                wait_toggle(100, c, e, a);
                nChecks++;
                if (c !== 1 || e !== 1) begin
                    nFails++;
                    $display("[TB] FAIL min_toggle cfg=%0d: got %0d edges=%0d expected 1 1",
                             vals[v], c, e);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int c, e, a;
        do_reset();
        cfg_half  = 32'd4;
        cfg_valid = 1'b1;
        @(negedge clk_100);
        cfg_valid = 1'b0;
        @(negedge clk_100);
        enable = 1'b1;
        wait_toggle(100, c, e, a);
        cfg_half  = 32'd7;
        cfg_valid = 1'b1;
        @(negedge clk_100);
        cfg_valid = 1'b0;
        nChecks++;
        if (cfg_ready !== 1'b0 || ant_out !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL abort_setup: got ready=%b ant=%b expected 0 1", cfg_ready, ant_out);
        end
        reset = 1'b1;
        @(negedge clk_100);
        nChecks++;
        if ({ant_out, cfg_ready, running, edge_stb, applied_stb} !== 5'b01000) begin
            nFails++;
            $display("[TB] FAIL abort_outputs: got %b expected 01000",
                     {ant_out, cfg_ready, running, edge_stb, applied_stb});
        end
        reset = 1'b0;
        wait_toggle(20000, c, e, a);
        nChecks++;
        if (c !== 10001 || a !== 0) begin
            nFails++;
            $display("[TB] FAIL abort_default_half: got %0d applies=%0d expected 10001 0", c, a);
        end
    endtask

    initial begin
        nChecks   = 0;
        nFails    = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_half  = '0;
        cfg_valid = 1'b0;
        @(negedge clk_100);
        test_reset();
        test_default_run();
        test_reconfig();
        test_back_to_back();
        test_stop();
        test_min_half();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
